// File: rtl/tile_absmax_quantizer.sv
// Buffers one tile of beats, tracks its absolute maximum, then replays it as symmetric
// power-of-two scaled integers. Define TILE_QUANT_ROUND_EN for round-half-up on right shifts.
module tile_absmax_quantizer #(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 1,
    parameter int IN_PARALLELISM = 4,
    parameter int IN_DEPTH       = 3,
    parameter int OUT_WIDTH      = 8,
    parameter int SW             = $clog2(IN_WIDTH) + 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [IN_PARALLELISM*IN_SIZE*IN_WIDTH-1:0]  data_in,
    input  logic                                        data_in_valid,
    output logic                                        data_in_ready,
    output logic [IN_PARALLELISM*IN_SIZE*OUT_WIDTH-1:0] data_out,
    output logic                                        data_out_valid,
    input  logic                                        data_out_ready,
    output logic                                        data_out_last,
    output logic [IN_WIDTH-1:0]                         max_num,
    output logic [SW-1:0]                               shift
);

    localparam int N  = IN_PARALLELISM * IN_SIZE;
    localparam int CW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    // Wide enough for the rounding add and the largest left shift without wrap.
    localparam int QW = IN_WIDTH + OUT_WIDTH + 2;

    localparam logic [CW-1:0]              LAST_IDX = CW'(IN_DEPTH - 1);
    localparam logic signed [IN_WIDTH-1:0] IN_MIN   = {1'b1, {(IN_WIDTH-1){1'b0}}};
    localparam logic [IN_WIDTH-1:0]        IN_MAX   = {1'b0, {(IN_WIDTH-1){1'b1}}};
    localparam logic signed [QW-1:0]       Q_HI     = QW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [QW-1:0]       Q_LO     = -Q_HI;

    typedef enum logic [1:0] {COLLECT, COMPUTE, EMIT} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           wr_cnt, rd_cnt;
    logic [IN_WIDTH-1:0]     absmax_q, beat_max;
    logic [N*IN_WIDTH-1:0]   tile_buf [IN_DEPTH];
    logic [N*IN_WIDTH-1:0]   rd_beat;
    logic                    in_fire, out_fire;

    function automatic logic [IN_WIDTH-1:0] abs_sat(input logic signed [IN_WIDTH-1:0] x);
        logic [IN_WIDTH-1:0] u;
        u = x;
        if (x == IN_MIN) return IN_MAX;
        return x[IN_WIDTH-1] ? (~u + IN_WIDTH'(1)) : u;
    endfunction

    function automatic int msb_index(input logic [IN_WIDTH-1:0] a);
        int e;
        e = 0;
        for (int i = 0; i < IN_WIDTH; i++)
            if (a[i]) e = i;
        return e;
    endfunction

    function automatic logic signed [QW-1:0] shift_scale(input logic signed [IN_WIDTH-1:0] x,
                                                         input logic signed [SW-1:0]       sh);
        logic signed [QW-1:0] xw;
        int                   sa;
        xw = {{(QW-IN_WIDTH){x[IN_WIDTH-1]}}, x};
        sa = int'(sh);
        if (sa > 0) begin
`ifdef TILE_QUANT_ROUND_EN
            xw = xw + (QW'(1) <<< (sa - 1));
`endif
            return xw >>> sa;
        end
        return xw <<< (-sa);
    endfunction

    // Symmetric clamp: the most negative code is never produced.
    function automatic logic [OUT_WIDTH-1:0] sat_sym(input logic signed [QW-1:0] q);
        if (q > Q_HI) return Q_HI[OUT_WIDTH-1:0];
        if (q < Q_LO) return Q_LO[OUT_WIDTH-1:0];
        return q[OUT_WIDTH-1:0];
    endfunction

    assign in_fire  = data_in_valid & data_in_ready;
    assign out_fire = data_out_valid & data_out_ready;
    assign rd_beat  = tile_buf[rd_cnt];

    always_comb begin
        beat_max = '0;
        for (int i = 0; i < N; i++)
            if (abs_sat(data_in[i*IN_WIDTH +: IN_WIDTH]) > beat_max)
                beat_max = abs_sat(data_in[i*IN_WIDTH +: IN_WIDTH]);
    end

    always_comb begin
        state_d        = state_q;
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        data_out_last  = 1'b0;
        case (state_q)
            COLLECT: begin
                data_in_ready = 1'b1;
                if (data_in_valid && wr_cnt == LAST_IDX) state_d = COMPUTE;
            end
            COMPUTE: state_d = EMIT;
            EMIT: begin
                data_out_valid = 1'b1;
                data_out_last  = (rd_cnt == LAST_IDX);
                if (data_out_ready && data_out_last) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= COLLECT;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            absmax_q <= '0;
            max_num  <= '0;
            shift    <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                absmax_q <= (beat_max > absmax_q) ? beat_max : absmax_q;
                wr_cnt   <= (wr_cnt == LAST_IDX) ? '0 : wr_cnt + CW'(1);
            end
            if (state_q == COMPUTE) begin
                max_num <= absmax_q;
                shift   <= SW'(msb_index(absmax_q) - (OUT_WIDTH - 2));
            end
            if (out_fire) begin
                if (data_out_last) begin
                    rd_cnt   <= '0;
                    absmax_q <= '0;
                end else begin
                    rd_cnt <= rd_cnt + CW'(1);
                end
            end
        end
    end

    // Tile storage holds data only; validity is tracked by the FSM.
    always_ff @(posedge clk) begin
        if (in_fire) tile_buf[wr_cnt] <= data_in;
    end

    always_comb begin
        data_out = '0;
        if (state_q == EMIT)
            for (int i = 0; i < N; i++)
                data_out[i*OUT_WIDTH +: OUT_WIDTH] =
                    sat_sym(shift_scale(rd_beat[i*IN_WIDTH +: IN_WIDTH], $signed(shift)));
    end

endmodule

// File: tb/tb_tile_absmax_quantizer.sv
// Self-checking bench for tile_absmax_quantizer: directed tile table, backpressure and
// mid-tile reset sequences, then random tiles checked against an arithmetic model.
`timescale 1ns/1ps
module tb_tile_absmax_quantizer;

    localparam int IW  = 16;
    localparam int OW  = 8;
    localparam int NE  = 4;
    localparam int D   = 3;
    localparam int SWD = $clog2(IW) + 1;
    localparam int TE  = NE * D;
`ifdef TILE_QUANT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NE*IW-1:0]  data_in;
    logic              data_in_valid;
    logic              data_in_ready;
    logic [NE*OW-1:0]  data_out;
    logic              data_out_valid;
    logic              data_out_ready;
    logic              data_out_last;
    logic [IW-1:0]     max_num;
    logic [SWD-1:0]    shift;

    always #5 clk = ~clk;

    tile_absmax_quantizer #(
        .IN_WIDTH(IW), .IN_SIZE(1), .IN_PARALLELISM(NE), .IN_DEPTH(D),
        .OUT_WIDTH(OW), .SW(SWD)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out_last(data_out_last), .max_num(max_num), .shift(shift)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int tx [TE];
    int eq [TE];
    int em, es;

    typedef struct {
        int x0, x1, x2, x3;
        int q0, q1, q2, q3;
        int maxn;
        int sh;
    } row_t;
    row_t tbl [18];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int el_out(input int i);
        return int'($signed(data_out[i*OW +: OW]));
    endfunction

    // Reference: absmax over the tile, exponent by magnitude, then scale and clamp.
    task automatic model_tile();
        int m, e, a, q, qmax, amax;
        qmax = (1 << (OW - 1)) - 1;
        amax = (1 << (IW - 1)) - 1;
        m = 0;
        for (int k = 0; k < TE; k++) begin
            a = (tx[k] < 0) ? -tx[k] : tx[k];
            if (a > amax) a = amax;
            if (a > m) m = a;
        end
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        em = m;
        es = e - (OW - 2);
        for (int k = 0; k < TE; k++) begin
            if (es > 0) q = RND ? ((tx[k] + (1 << (es - 1))) >>> es) : (tx[k] >>> es);
            else        q = tx[k] * (1 << (-es));
            if (q > qmax)  q = qmax;
            if (q < -qmax) q = -qmax;
            eq[k] = q;
        end
    endtask

    task automatic load_tile(input int k);
        row_t r;
        for (int b = 0; b < D; b++) begin
            r = tbl[k*D + b];
            tx[b*NE+0] = r.x0; tx[b*NE+1] = r.x1; tx[b*NE+2] = r.x2; tx[b*NE+3] = r.x3;
            eq[b*NE+0] = r.q0; eq[b*NE+1] = r.q1; eq[b*NE+2] = r.q2; eq[b*NE+3] = r.q3;
            em = r.maxn;
            es = r.sh;
        end
    endtask

    task automatic check_beat(input int b);
        for (int i = 0; i < NE; i++)
            chk($sformatf("q[%0d][%0d]", b, i), el_out(i), eq[b*NE+i]);
        chk($sformatf("last[%0d]", b), int'(data_out_last), int'(b == D - 1));
        chk("max_num", int'(max_num), em);
        chk("shift", int'($signed(shift)), es);
        chk("in_ready_emit", int'(data_in_ready), 0);
    endtask

    task automatic run_tile(input int stall_beat, input int stall_n, input bit chk_lat,
                            input bit hold, input int n_rx);
        int t;
        for (int b = 0; b < D; b++) begin
            for (int i = 0; i < NE; i++) data_in[i*IW +: IW] = tx[b*NE+i][IW-1:0];
            data_in_valid = 1'b1;
            t = 0;
            while (!data_in_ready && t < 40) begin @(posedge clk); #1; t++; end
            chk("in_ready", int'(data_in_ready), 1);
            @(posedge clk); #1;
        end
        if (!hold) data_in_valid = 1'b0;
        if (chk_lat) begin
            chk("bubble_valid", int'(data_out_valid), 0);
            @(posedge clk); #1;
            chk("first_valid", int'(data_out_valid), 1);
        end
        for (int b = 0; b < n_rx; b++) begin
            t = 0;
            while (!data_out_valid && t < 40) begin @(posedge clk); #1; t++; end
            chk("out_valid", int'(data_out_valid), 1);
            check_beat(b);
            if (b == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk); #1;
                    chk("stall_valid", int'(data_out_valid), 1);
                    check_beat(b);
                end
            end
            data_out_ready = 1'b1;
            @(posedge clk); #1;
            data_out_ready = 1'b0;
        end
        if (n_rx == D) chk("ready_after_tile", int'(data_in_ready), 1);
    endtask

    task automatic random_tile();
        int top, sc, mag, v;
        top = $urandom_range(0, 15);
        for (int k = 0; k < TE; k++) begin
            sc  = $urandom_range(0, top);
            mag = 1 << sc;
            v   = int'($urandom_range(0, 2 * mag)) - mag;
            if (v > 32767) v = 32767;
            if ($urandom_range(0, 19) == 0) v = -32768;
            if ($urandom_range(0, 9) == 0) v = 0;
            tx[k] = v;
        end
        model_tile();
    endtask

    initial begin
        // basic tile
        tbl[0]  = '{100, -50, 3, 0,   RND ? 13 : 12, RND ? -6 : -7, 0, 0,    1000, 3};
        tbl[1]  = '{1000, 7, -8, 1,   125, RND ? 1 : 0, -1, 0,                1000, 3};
        tbl[2]  = '{0, 0, 0, 0,       0, 0, 0, 0,                             1000, 3};
        // small magnitude, negative shift
        tbl[3]  = '{5, -3, 0, 0,      80, -48, 0, 0,                          5, -4};
        tbl[4]  = '{1, 0, 0, 0,       16, 0, 0, 0,                            5, -4};
        tbl[5]  = '{0, 0, 0, -5,      0, 0, 0, -80,                           5, -4};
        // most negative input saturates absmax
        tbl[6]  = '{-32768, 1020, 0, 0, -127, RND ? 4 : 3, 0, 0,              32767, 8};
        tbl[7]  = '{255, -128, 0, 0,  RND ? 1 : 0, RND ? 0 : -1, 0, 0,        32767, 8};
        tbl[8]  = '{0, 0, 0, 0,       0, 0, 0, 0,                             32767, 8};
        // output clamp at +/-127
        tbl[9]  = '{1020, 1023, -1023, 0, 127, 127, -127, 0,                  1023, 3};
        tbl[10] = '{8, -4, 3, -3,     1, RND ? 0 : -1, 0, RND ? 0 : -1,       1023, 3};
        tbl[11] = '{0, 0, 0, 0,       0, 0, 0, 0,                             1023, 3};
        // all-zero tile
        tbl[12] = '{0, 0, 0, 0,       0, 0, 0, 0,                             0, -6};
        tbl[13] = '{0, 0, 0, 0,       0, 0, 0, 0,                             0, -6};
        tbl[14] = '{0, 0, 0, 0,       0, 0, 0, 0,                             0, -6};
        // negative-dominated tile
        tbl[15] = '{-1, -2, -3, -4,   -16, -32, -48, -64,                     4, -4};
        tbl[16] = '{0, 0, 0, 1,       0, 0, 0, 16,                            4, -4};
        tbl[17] = '{2, 0, 0, 0,       32, 0, 0, 0,                            4, -4};

        rst            = 1'b0;
        data_in        = '1;
        data_in_valid  = 1'b1;
        data_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",    int'(data_out_valid), 0);
        chk("rst_last",     int'(data_out_last), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_max_num",  int'(max_num), 0);
        chk("rst_shift",    int'(shift), 0);
        chk("rst_in_ready", int'(data_in_ready), 1);
        data_in_valid = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 6; k++) begin
            load_tile(k);
            run_tile(-1, 0, k == 0, 1'b0, D);
        end

        // backpressure on out1 with upstream valid held high
        load_tile(0);
        run_tile(1, 5, 1'b1, 1'b1, D);

        // reset after out0 of a large tile
        for (int k = 0; k < TE; k++) tx[k] = (k % 2 == 0) ? 30000 - k : -20000 + k;
        model_tile();
        run_tile(-1, 0, 1'b0, 1'b0, 1);
        rst = 1'b0;
        #1;
        chk("midrst_valid",    int'(data_out_valid), 0);
        chk("midrst_max_num",  int'(max_num), 0);
        chk("midrst_in_ready", int'(data_in_ready), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("post_rst_no_output", int'(data_out_valid), 0);
        end
        load_tile(1);
        run_tile(-1, 0, 1'b1, 1'b0, D);

        for (int n = 0; n < 30; n++) begin
            random_tile();
            run_tile(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'b0,
                     1'($urandom_range(0, 1)), D);
        end
        data_in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_absmax_quantizer.md
# tile_absmax_quantizer

Upstream stage of the int8 matmul path. Buffers one tile of `IN_DEPTH` input beats and tracks the tile's absolute maximum across all of them. It then replays the tile as symmetric `OUT_WIDTH`-bit integers, scaled by a power-of-two shift, together with the tile's `max_num`. The int8 core consumes the integers; the dequantizer path consumes `max_num`.

## Interface
- `IN_WIDTH`, 16: signed input element width.
- `IN_SIZE`, 1: columns per beat.
- `IN_PARALLELISM`, 4: rows per beat; N = `IN_PARALLELISM*IN_SIZE` elements per beat.
- `IN_DEPTH`, 3: beats per tile; must be ≥1.
- `OUT_WIDTH`, 8: signed quantized element width.
- `SW`, `$clog2(IN_WIDTH)+1`: width of the signed `shift` output.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `data_in` in `[IN_WIDTH-1:0]` x N: input beat, signed.
- `data_in_valid` in 1; `data_in_ready` out 1.
- `data_out` out `[OUT_WIDTH-1:0]` x N: quantized beat.
- `data_out_valid` out 1; `data_out_ready` in 1.
- `data_out_last` out 1: high on the final beat of a tile.
- `max_num` out `IN_WIDTH`: tile absmax, unsigned, constant for the whole tile.
- `shift` out `SW`, signed: e − (`OUT_WIDTH`−2), constant for the whole tile.

## Operation
- FSM states:
  - COLLECT (reset state).
  - COMPUTE.
  - EMIT.
- COLLECT:
  - `data_in_ready`=1.
  - Each handshake writes the beat to `buf[wr_cnt]` and updates `absmax` = max(`absmax`, |x|) over all N elements.
  - |−2^(IN_WIDTH−1)| saturates to 2^(IN_WIDTH−1)−1.
  - When the handshake is at `wr_cnt`=`IN_DEPTH`−1: go to COMPUTE and clear `wr_cnt`.
- COMPUTE (exactly 1 cycle):
  - `data_in_ready`=0.
  - Register `max_num`=`absmax`.
  - e = bit index of the MSB of `absmax` (0 when `absmax`=0).
  - Register `shift` = e−(`OUT_WIDTH`−2).
  - Go to EMIT.
- EMIT:
  - `data_in_ready`=0 and `data_out_valid`=1.
  - `data_out` = quantize(`buf[rd_cnt]`).
  - Each output handshake increments `rd_cnt`.
  - `data_out_last` = (`rd_cnt`==`IN_DEPTH`−1).
  - On the last handshake: clear `rd_cnt` and `absmax`, then go to COLLECT.
- quantize(x), per element:
  - If `shift`>0: q = (x + 2^(`shift`−1)) >>> `shift`, an arithmetic shift.
  - Otherwise: q = x << −`shift`.
  - Saturate q to the symmetric range [−(2^(`OUT_WIDTH`−1)−1), 2^(`OUT_WIDTH`−1)−1]; −2^(`OUT_WIDTH`−1) is never produced.
- All-zero tile: `max_num`=0, `shift`=−(`OUT_WIDTH`−2), all outputs 0.

## Timing
- Reset (`rst`=0), asynchronous:
  - State goes to COLLECT.
  - Counters and `absmax` are cleared.
  - `data_out_valid`=0, `data_out_last`=0, `data_out`=0, `max_num`=0, `shift`=0.
  - `data_in_ready`=1, but no beat is accepted until `rst`=1.
- Latency:
  - The edge accepting the last input beat enters COMPUTE.
  - The next edge enters EMIT.
  - `data_out_valid` is high in the 2nd cycle after that accept edge (one bubble cycle).
  - Minimum tile period is 2·`IN_DEPTH`+1 cycles.
- Handshake:
  - Valid/ready transfer occurs when both are high at a rising edge.
  - While `data_out_valid`=1 and `data_out_ready`=0, `data_out`, `data_out_last`, `max_num` and `shift` hold stable.
  - `data_out_valid` never drops without a handshake.
- `max_num` and `shift` remain valid from COMPUTE exit until the next COMPUTE, so they may be sampled on any output beat.
- Input behaviour: no input is accepted during COMPUTE or EMIT. `data_in_valid` may stay high; the beat is held by upstream.
- `rst` asserted mid-tile, in any state: the partial tile is discarded, with no partial output. Output resumes only after a complete new tile.

## Configuration
- `TILE_QUANT_ROUND_EN` defined: the positive-shift path adds 2^(`shift`−1) before the arithmetic shift (round-half-up), as specified above.
- Not defined: pure arithmetic shift (floor truncation), with no rounding adder. Saturation still applies.
- Expected values in the test plan assume `TILE_QUANT_ROUND_EN` is defined.

## Test plan
All scenarios use defaults (16b → 8b, N=4, DEPTH=3) with `TILE_QUANT_ROUND_EN` defined unless stated.

- Basic tile:
  - Stimulus: beats {100,−50,3,0}, {1000,7,−8,1}, {0,0,0,0}.
  - Response: `max_num`=1000, `shift`=3; out0={13,−6,0,0}, out1={125,1,−1,0}, out2={0,0,0,0}; `data_out_last` only on out2; first valid 2 cycles after the 3rd accept.
- Small magnitude:
  - Stimulus: tile max 5, containing 5 and −3.
  - Response: `shift`=−4; outputs 80 and −48.
- Saturation:
  - Stimulus: element −32768 with 1020 in the same tile.
  - Response: `max_num`=32767, `shift`=8; −32768→−127, 1020→4 (i.e. (1020+128)>>>8). Separately, a tile with max 1023 maps 1020→127, not 128.
- All-zero tile:
  - Stimulus: three zero beats.
  - Response: `max_num`=0, `shift`=−6, all outputs 0. The undefined-macro build gives the same result, and 1020 with max 1023 maps to 127 by truncation.
- Backpressure:
  - Stimulus: `data_out_ready`=0 for 5 cycles on out1, with `data_in_valid` held high throughout.
  - Response: out1 and all sideband outputs are stable; `data_in_ready`=0 throughout; the next tile is accepted the cycle after the out2 handshake.
- Reset mid-EMIT:
  - Stimulus: pull `rst` low after out0 is accepted.
  - Response: `data_out_valid` falls immediately, with no out1 or out2. A following fresh tile produces correct results with `absmax` not polluted by the old tile.
